// File: rtl/dmem_ctrl.sv
// dmem_ctrl: pipeline data-memory controller; stalls on loads, posts stores.
// Optional alignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              we,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;
  logic [31:0] rdata_q;
  logic [31:0] rdata_nx;
  logic        err_q;
  logic        err_nx;
  logic        misalign;
  logic        unused_addr;

  assign unused_addr = ^{data_addr[31:ADDR_W+2],
                         data_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |data_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr = data_addr[ADDR_W+1:2];
  assign mem_din  = din;
  assign dout     = rdata_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  // Issue-side outputs are gated by rstn so a held
  // request cannot stall or enable the RAM in reset.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            err_nx = 1'b1;
          end else begin
            mem_en = rstn;
            mem_we = rstn & we;
            if (!we) begin
              stall    = rstn;
              cnt_nx   = LAT;
              state_nx = WAIT;
            end
          end
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) begin
          rdata_nx = mem_dout;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl at read latency 1 and 3.
// Covers the DMEM_ALIGN_CHECK_EN path when that macro is defined.
module tb_dmem_ctrl;

  logic clk;
  logic rstn;

  logic        rv_a, we_a, st_a, en_a, mw_a, er_a;
  logic [31:0] ad_a, di_a, do_a, md_a, mo_a;
  logic [7:0]  ma_a;
  logic        rv_b, we_b, st_b, en_b, mw_b, er_b;
  logic [31:0] ad_b, di_b, do_b, md_b, mo_b;
  logic [7:0]  ma_b;

  int checks   = 0;
  int failures = 0;
  int ecnt_a   = 0;
  int e0;

  dmem_ctrl #(.ADDR_W(8), .READ_LATENCY(1)) u_a (
    .clk(clk), .rstn(rstn),
    .req_valid(rv_a), .we(we_a),
    .data_addr(ad_a), .din(di_a),
    .dout(do_a), .stall(st_a),
    .mem_en(en_a), .mem_we(mw_a),
    .mem_addr(ma_a), .mem_din(md_a),
    .mem_dout(mo_a), .err(er_a)
  );

  dmem_ctrl #(.ADDR_W(8), .READ_LATENCY(3)) u_b (
    .clk(clk), .rstn(rstn),
    .req_valid(rv_b), .we(we_b),
    .data_addr(ad_b), .din(di_b),
    .dout(do_b), .stall(st_b),
    .mem_en(en_b), .mem_we(mw_b),
    .mem_addr(ma_b), .mem_din(md_b),
    .mem_dout(mo_b), .err(er_b)
  );

  // Synchronous RAM models: write-first across cycles,
  // read data valid READ_LATENCY cycles after mem_en.
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] pa;
  logic [31:0] pb0, pb1, pb2;

  assign mo_a = pa;
  assign mo_b = pb2;

  always @(posedge clk) begin
    if (en_a && mw_a) ram_a[ma_a] <= md_a;
    pa <= (en_a && !mw_a) ? ram_a[ma_a] : 32'h0;
    if (en_a) ecnt_a <= ecnt_a + 1;
  end

  always @(posedge clk) begin
    if (en_b && mw_b) ram_b[ma_b] <= md_b;
    pb0 <= (en_b && !mw_b) ? ram_b[ma_b] : 32'h0;
    pb1 <= pb0;
    pb2 <= pb1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    rv_a = 1'b1; we_a = 1'b0; ad_a = 32'h10; di_a = '0;
    rv_b = 1'b0; we_b = 1'b0; ad_b = '0;     di_b = '0;
    #2;
    chk("rst_stall", st_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_dout", do_a, 0);
    chk("rst_err", er_a, 0);
    tick();
    tick();
    rv_a = 1'b0;
    rstn = 1'b1;
    #2;
    chk("rel_stall", st_a, 0);
    chk("rel_dout", do_a, 0);
    chk("rel_en", en_a, 0);
    tick();

    // Back-to-back stores on both instances
    rv_a = 1'b1; we_a = 1'b1; ad_a = 32'h10; di_a = 32'hDEADBEEF;
    rv_b = 1'b1; we_b = 1'b1; ad_b = 32'h10; di_b = 32'hDEADBEEF;
    #2;
    chk("st0_en", en_a, 1);
    chk("st0_we", mw_a, 1);
    chk("st0_addr", ma_a, 4);
    chk("st0_din", md_a, 32'hDEADBEEF);
    chk("st0_stall", st_a, 0);
    chk("st0_stall_b", st_b, 0);
    tick();
    ad_a = 32'h14; di_a = 32'h12345678;
    ad_b = 32'h14; di_b = 32'h12345678;
    #2;
    chk("st1_we", mw_a, 1);
    chk("st1_addr", ma_a, 5);
    chk("st1_stall", st_a, 0);
    chk("st1_we_b", mw_b, 1);
    chk("st1_stall_b", st_b, 0);
    tick();

    // Loads: a from 0x10 (lat 1), b from 0x14 (lat 3)
    we_a = 1'b0; ad_a = 32'h10;
    we_b = 1'b0; ad_b = 32'h14;
    e0 = ecnt_a;
    #2;
    chk("ld_a_c0_stall", st_a, 1);
    chk("ld_a_c0_en", en_a, 1);
    chk("ld_a_c0_we", mw_a, 0);
    chk("ld_b_c0_stall", st_b, 1);
    chk("ld_b_c0_en", en_b, 1);
    tick();
    #2;
    chk("ld_a_c1_stall", st_a, 1);
    chk("ld_a_c1_en", en_a, 0);
    chk("ld_b_c1_stall", st_b, 1);
    chk("ld_b_c1_en", en_b, 0);
    tick();
    #2;
    chk("ld_a_done_stall", st_a, 0);
    chk("ld_a_done_dout", do_a, 32'hDEADBEEF);
    chk("ld_a_done_en", en_a, 0);
    chk("ld_a_done_we", mw_a, 0);
    chk("ld_b_c2_stall", st_b, 1);
    tick();
    rv_a = 1'b0;
    #2;
    chk("ld_a_hold", do_a, 32'hDEADBEEF);
    chk("ld_a_idle_stall", st_a, 0);
    chk("ld_a_pulses", ecnt_a - e0, 1);
    chk("ld_b_c3_stall", st_b, 1);
    tick();
    #2;
    chk("ld_b_done_stall", st_b, 0);
    chk("ld_b_done_dout", do_b, 32'h12345678);
    chk("ld_b_done_en", en_b, 0);
    tick();
    we_b = 1'b1; ad_b = 32'h18; di_b = 32'hA5A55A5A;
    #2;
    chk("st_after_b_stall", st_b, 0);
    chk("st_after_b_en", en_b, 1);
    chk("st_after_b_we", mw_b, 1);
    chk("st_after_b_addr", ma_b, 6);
    tick();
    rv_b = 1'b0;

    // Reset in the middle of a load
    rv_a = 1'b1; we_a = 1'b0; ad_a = 32'h10;
    #2;
    chk("rl_c0_stall", st_a, 1);
    tick();
    #2;
    chk("rl_wait_stall", st_a, 1);
    rstn = 1'b0;
    #1;
    chk("rl_rst_stall", st_a, 0);
    chk("rl_rst_dout", do_a, 0);
    chk("rl_rst_en", en_a, 0);
    chk("rl_rst_dout_b", do_b, 0);
    tick();
    rstn = 1'b1;
    ad_a = 32'h14;
    #2;
    chk("rl_new_stall", st_a, 1);
    chk("rl_new_en", en_a, 1);
    tick();
    #2;
    chk("rl_new_wait", st_a, 1);
    tick();
    #2;
    chk("rl_new_done_stall", st_a, 0);
    chk("rl_new_dout", do_a, 32'h12345678);
    tick();

`ifdef DMEM_ALIGN_CHECK_EN
    we_a = 1'b1; ad_a = 32'h12; di_a = 32'h0;
    #2;
    chk("mis_en", en_a, 0);
    chk("mis_we", mw_a, 0);
    chk("mis_stall", st_a, 0);
    chk("mis_err_pre", er_a, 0);
    tick();
    we_a = 1'b0; ad_a = 32'h10;
    #2;
    chk("mis_err_post", er_a, 1);
    chk("mis_dout", do_a, 32'h12345678);
    chk("al_ld_stall", st_a, 1);
    tick();
    tick();
    #2;
    chk("al_ld_dout", do_a, 32'hDEADBEEF);
    chk("al_err_sticky", er_a, 1);
`else
    we_a = 1'b1; ad_a = 32'h12; di_a = 32'hDEADBEEF;
    #2;
    chk("nochk_en", en_a, 1);
    chk("nochk_addr", ma_a, 4);
    chk("nochk_err", er_a, 0);
    tick();
    we_a = 1'b0; ad_a = 32'h10;
    #2;
    chk("nochk_err_post", er_a, 0);
    chk("nochk_ld_stall", st_a, 1);
    tick();
    tick();
    #2;
    chk("nochk_ld_dout", do_a, 32'hDEADBEEF);
`endif
    tick();
    rv_a = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sits directly downstream of the pipeline memory-access stage and consumes its raw data-memory request (we, data_addr, din).
- Drives a synchronous block RAM with a fixed read latency and returns read data on dout.
- Asserts stall to freeze the pipeline while a load is outstanding. Stores are posted and take a single cycle.

Parameters:
- ADDR_W, 16, word-address width of the RAM (depth = 2**ADDR_W words).
- READ_LATENCY, 1, cycles from mem_en to valid mem_dout; legal range 1..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage holds a valid memory instruction this cycle.
- we  in  1  1 = store, 0 = load (sampled only when req_valid=1).
- data_addr  in  32  byte address from the MEM stage.
- din  in  32  store data.
- dout  out  32  load data returned to the MEM stage.
- stall  out  1  pipeline must hold all upstream registers and the request inputs.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address = data_addr[ADDR_W+1:2]; upper bits are ignored (wrap).
- mem_din  out  32  RAM write data = din.
- mem_dout  in  32  RAM read data.
- err  out  1  sticky misalignment flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, rstn=0): state=IDLE, cnt=0, rdata_q=0, err=0. Outputs are dout=0, stall=0, mem_en=0, mem_we=0.
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE, req_valid=0:
  - mem_en=0, stall=0, state stays IDLE.
- IDLE, req_valid=1, we=1 (store):
  - mem_en=1 and mem_we=1 combinationally in the same cycle; stall=0; state stays IDLE.
  - Back-to-back stores complete at one per cycle.
- IDLE, req_valid=1, we=0 (load):
  - mem_en=1, mem_we=0, stall=1 combinationally.
  - At the clock edge: cnt<=READ_LATENCY, state<=WAIT.
- WAIT:
  - stall=1, mem_en=0, cnt decrements each edge.
  - When cnt==1: rdata_q<=mem_dout at that edge, state<=DONE.
- DONE:
  - stall=0; the held load retires at the end of this cycle.
  - No re-issue even though req_valid is still high with the same request.
  - state<=IDLE unconditionally.
- Load timing:
  - A load occupies READ_LATENCY+2 cycles, with stall high for READ_LATENCY+1 of them.
  - A request arriving in the cycle after DONE is treated as new.
- dout = rdata_q at all times; it holds the last load value until the next load captures.
- mem_addr and mem_din are combinational from the inputs in every state. The upstream stage holds them stable while stall=1.
- mem_we is asserted only in IDLE with a store request. It is never asserted in WAIT or DONE.
- Read-after-write (store then load to the same address in consecutive cycles) relies on RAM write-first-then-read ordering across cycles. No bypass is implemented.
- Reset mid-load (any state): returns to IDLE immediately; stall drops asynchronously; the pending read is discarded and dout=0.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - In IDLE, a request with req_valid=1 and data_addr[1:0]!=0 is suppressed: mem_en=0, mem_we=0, no stall, state stays IDLE.
  - err is set at the edge and stays 1 until reset.
  - dout is unchanged.
- When undefined:
  - The low two address bits are ignored, every request is performed at the truncated word address, and err is constant 0.

Test Plan:
- Reset with rstn=0 mid-stream, then release -> dout=0, stall=0, mem_en=0, err=0.
- Stores to 0x0000_0010 (din=0xDEADBEEF) and 0x0000_0014 (din=0x12345678) in consecutive cycles -> mem_we high both cycles at mem_addr 4 and 5; stall never asserted.
- READ_LATENCY=1: load from 0x10 after the store above -> stall high for exactly 2 cycles, dout=0xDEADBEEF in the DONE cycle and held afterwards; exactly one mem_en pulse.
- READ_LATENCY=3: load from 0x14 -> stall high for 4 cycles, dout=0x12345678; a store presented in the cycle after DONE completes without stall.
- Assert rstn=0 during WAIT of a load from 0x10 -> stall falls immediately, dout=0, and after release the next load from 0x14 returns 0x12345678.
- With DMEM_ALIGN_CHECK_EN: store to 0x0000_0012 -> mem_en stays 0, err=1 from the next cycle, and a following aligned load still returns correct data.
